// File: rtl/pattern_life_pkg.sv
// Shared types and constants for the pattern life engine.
// Latency: n/a (declarations and one pure function only).
// Backpressure: n/a.
package pattern_life_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COMPUTE = 2'd1,
      ST_COMMIT  = 2'd2,
      ST_SEED    = 2'd3
   } state_e;

   // MAX7219 digit registers are addressed 1..8, so digit d uses address d+1.
   localparam logic [3:0]  DIGIT_BASE = 4'd1;

   // Galois mask for x^32 + x^22 + x^2 + x + 1 (right-shifting form).
   localparam logic [31:0] LFSR_TAPS  = 32'h8020_0003;

   // Eight neighbours need a 4-bit count.
   localparam int          NBR_W      = 4;

   function automatic logic [31:0] lfsr_step(input logic [31:0] s);
      return {1'b0, s[31:1]} ^ (s[0] ? LFSR_TAPS : 32'h0);
   endfunction

endpackage

// File: rtl/pattern_life_engine_if.sv
// Control and display bundle between a host and the pattern life engine.
// Latency: n/a (wires only).
// Backpressure: none; the engine drops control pulses it cannot act on.
// master : drives i_AliensArrived/i_Wrap/i_Pause/i_Step, reads display/status.
// slave  : the engine side of the same signals.
interface pattern_life_engine_if #(
   parameter int DISP_ROWS    = 1,
   parameter int DISP_COLUMNS = 1,
   parameter int GEN_WIDTH    = 16
);
   logic                                               i_AliensArrived;
   logic                                               i_Wrap;
   logic                                               i_Pause;
   logic                                               i_Step;
   logic [0:7][DISP_ROWS-1:0][DISP_COLUMNS-1:0][15:0] o_MAX7219_DataStream;
   logic [GEN_WIDTH-1:0]                               o_Generation;
   logic                                               o_Stagnant;

   modport master (
      output i_AliensArrived, i_Wrap, i_Pause, i_Step,
      input  o_MAX7219_DataStream, o_Generation, o_Stagnant
   );

   modport slave (
      input  i_AliensArrived, i_Wrap, i_Pause, i_Step,
      output o_MAX7219_DataStream, o_Generation, o_Stagnant
   );
endinterface

// File: rtl/life_row_next.sv
// B3/S23 next state for one grid row from its two vertical neighbour rows.
// Latency: combinational.
// Backpressure: none.
// Ports: above_i/cur_i/below_i rows (bit c = column c), wrap_i toroidal
//        column edges, nxt_o next row.
module life_row_next
   import pattern_life_pkg::*;
#(
   parameter int W = 8
) (
   input  logic [W-1:0] above_i,
   input  logic [W-1:0] cur_i,
   input  logic [W-1:0] below_i,
   input  logic         wrap_i,
   output logic [W-1:0] nxt_o
);

   // Bit c of a "left" row holds column c-1, of a "right" row column c+1;
   // the edge column is either the opposite edge or a dead cell.
   function automatic logic [W-1:0] sh_l(input logic [W-1:0] v, input logic wr);
      return {v[W-2:0], wr & v[W-1]};
   endfunction

   function automatic logic [W-1:0] sh_r(input logic [W-1:0] v, input logic wr);
      return {wr & v[0], v[W-1:1]};
   endfunction

   function automatic logic [NBR_W-1:0] pop8(input logic [7:0] v);
      logic [NBR_W-1:0] s;
      s = '0;
      for (int i = 0; i < 8; i++) s = s + NBR_W'(v[i]);
      return s;
   endfunction

   logic [W-1:0] a_l, a_r, c_l, c_r, b_l, b_r;
   logic [NBR_W-1:0] cnt;

   assign a_l = sh_l(above_i, wrap_i);
   assign a_r = sh_r(above_i, wrap_i);
   assign c_l = sh_l(cur_i,   wrap_i);
   assign c_r = sh_r(cur_i,   wrap_i);
   assign b_l = sh_l(below_i, wrap_i);
   assign b_r = sh_r(below_i, wrap_i);

   always_comb begin
      nxt_o = '0;
      cnt   = '0;
      for (int c = 0; c < W; c++) begin
         cnt = pop8({a_l[c], above_i[c], a_r[c],
                     c_l[c],             c_r[c],
                     b_l[c], below_i[c], b_r[c]});
         nxt_o[c] = (cnt == NBR_W'(3)) | (cur_i[c] & (cnt == NBR_W'(2)));
      end
   end

endmodule

// File: rtl/pattern_life_engine.sv
// Conway life engine driving a grid of MAX7219 8x8 modules, with LFSR seeding.
// Latency: a trigger at edge k shows the new generation after edge k+H+1.
// Backpressure: none; ticks arriving outside IDLE are dropped.
// Ports: i_Clk, i_Rst (sync, active-high); bus = control inputs
//        (aliens/wrap/pause/step) and display/generation/stagnant outputs.
module pattern_life_engine
   import pattern_life_pkg::*;
#(
   parameter int          DISP_ROWS    = 1,
   parameter int          DISP_COLUMNS = 1,
   parameter int          CLK_FREQ_HZ  = 8,
   parameter int          GEN_RATE_HZ  = 1,
   parameter logic [31:0] LFSR_SEED    = 32'hACE1_2468,
   parameter int          AUTO_RESEED  = 1,
   parameter int          GEN_WIDTH    = 16
) (
   input  logic                 i_Clk,
   input  logic                 i_Rst,
   pattern_life_engine_if.slave bus
);

   localparam int          H         = 8 * DISP_ROWS;
   localparam int          W         = 8 * DISP_COLUMNS;
   localparam int          N         = CLK_FREQ_HZ / GEN_RATE_HZ;
   localparam int          CNT_W     = (N > 1) ? $clog2(N) : 1;
   localparam int          RW        = $clog2(H);
   localparam int          CW        = $clog2(W);
   localparam logic [31:0] SEED_INIT = (LFSR_SEED == 32'h0) ? 32'h1 : LFSR_SEED;

   state_e               state_q, state_d;
   logic [CNT_W-1:0]     pre_q, pre_d;
   logic [31:0]          lfsr_q, lfsr_d;
   logic [GEN_WIDTH-1:0] gen_q, gen_d;
   logic                 stag_q, stag_d;
   logic                 pend_q, pend_d;
   logic                 wrap_q, wrap_d;
   logic [RW-1:0]        row_q, row_d;
   logic [CW-1:0]        col_q, col_d;

   logic [W-1:0] cur_q  [H];
   logic [W-1:0] prev_q [H];
   logic [W-1:0] nxt_q  [H];

   logic         tick, trigger, row_last, col_last, seed_done;
   logic         same_cur, same_prev, stag_now;
   logic [W-1:0] row_up, row_dn, row_nxt;
   logic [0:7][DISP_ROWS-1:0][DISP_COLUMNS-1:0][15:0] ds;

   function automatic logic [W-1:0] glider_row(input int r);
      logic [W-1:0] v;
      v = '0;
      case (r)
         0:       v[1]   = 1'b1;
         1:       v[2]   = 1'b1;
         2:       v[2:0] = 3'b111;
         default: v      = '0;
      endcase
      return v;
   endfunction

   assign tick      = (pre_q == CNT_W'(N - 1));
   assign trigger   = (tick & ~bus.i_Pause) | (bus.i_Step & bus.i_Pause);
   assign row_last  = (row_q == RW'(H - 1));
   assign col_last  = (col_q == CW'(W - 1));
   assign seed_done = row_last & col_last;

   // Vertical neighbours of the row being computed; off-grid rows are dead
   // unless the wrap flag latched for this generation is set.
   always_comb begin
      if (row_q == '0) row_up = wrap_q ? cur_q[H-1] : '0;
      else             row_up = cur_q[row_q - 1'b1];
      if (row_last)    row_dn = wrap_q ? cur_q[0] : '0;
      else             row_dn = cur_q[row_q + 1'b1];
   end

   life_row_next #(.W(W)) u_row (
      .above_i (row_up),
      .cur_i   (cur_q[row_q]),
      .below_i (row_dn),
      .wrap_i  (wrap_q),
      .nxt_o   (row_nxt)
   );

   // Still life when next equals current; period-2 when it equals previous.
   always_comb begin
      same_cur  = 1'b1;
      same_prev = 1'b1;
      for (int r = 0; r < H; r++) begin
         if (nxt_q[r] != cur_q[r])  same_cur  = 1'b0;
         if (nxt_q[r] != prev_q[r]) same_prev = 1'b0;
      end
   end
   assign stag_now = same_cur | same_prev;

   always_comb begin
      state_d = state_q;
      pre_d   = tick ? '0 : pre_q + 1'b1;
      pend_d  = pend_q | bus.i_AliensArrived;
      wrap_d  = wrap_q;
      row_d   = row_q;
      col_d   = col_q;
      lfsr_d  = lfsr_q;
      gen_d   = gen_q;
      stag_d  = stag_q;
      unique case (state_q)
         ST_IDLE: begin
            // A reseed request wins over a simultaneous generation trigger.
            if (pend_d) begin
               state_d = ST_SEED;
            end else if (trigger) begin
               state_d = ST_COMPUTE;
               wrap_d  = bus.i_Wrap;
            end
         end
         ST_COMPUTE: begin
            if (row_last) begin
               row_d   = '0;
               state_d = ST_COMMIT;
            end else begin
               row_d = row_q + 1'b1;
            end
         end
         ST_COMMIT: begin
            gen_d   = gen_q + 1'b1;
            stag_d  = stag_now;
            state_d = ((AUTO_RESEED != 0) && stag_now) ? ST_SEED : ST_IDLE;
         end
         ST_SEED: begin
            lfsr_d = lfsr_step(lfsr_q);
            if (col_last) begin
               col_d = '0;
               if (row_last) begin
                  row_d   = '0;
                  gen_d   = '0;
                  stag_d  = 1'b0;
                  pend_d  = 1'b0;
                  state_d = ST_IDLE;
               end else begin
                  row_d = row_q + 1'b1;
               end
            end else begin
               col_d = col_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         state_q <= ST_IDLE;
         pre_q   <= '0;
         lfsr_q  <= SEED_INIT;
         gen_q   <= '0;
         stag_q  <= 1'b0;
         pend_q  <= 1'b0;
         wrap_q  <= 1'b0;
         row_q   <= '0;
         col_q   <= '0;
         for (int r = 0; r < H; r++) begin
            cur_q[r]  <= glider_row(r);
            prev_q[r] <= '0;
            nxt_q[r]  <= '0;
         end
      end else begin
         state_q <= state_d;
         pre_q   <= pre_d;
         lfsr_q  <= lfsr_d;
         gen_q   <= gen_d;
         stag_q  <= stag_d;
         pend_q  <= pend_d;
         wrap_q  <= wrap_d;
         row_q   <= row_d;
         col_q   <= col_d;
         case (state_q)
            ST_COMPUTE: nxt_q[row_q] <= row_nxt;
            ST_COMMIT: begin
               for (int r = 0; r < H; r++) begin
                  prev_q[r] <= cur_q[r];
                  cur_q[r]  <= nxt_q[r];
               end
            end
            ST_SEED: begin
               cur_q[row_q][col_q] <= lfsr_q[0];
               if (seed_done) begin
                  for (int r = 0; r < H; r++) prev_q[r] <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   // Cell (r,c) lands in module [r/8][c/8], digit r%8, bit 7-(c%8).
   always_comb begin
      ds = '0;
      for (int mr = 0; mr < DISP_ROWS; mr++) begin
         for (int mc = 0; mc < DISP_COLUMNS; mc++) begin
            for (int d = 0; d < 8; d++) begin
               ds[d][mr][mc][15:8] = {4'h0, DIGIT_BASE + 4'(d)};
               for (int b = 0; b < 8; b++) begin
                  ds[d][mr][mc][7-b] = cur_q[mr*8 + d][mc*8 + b];
               end
            end
         end
      end
   end

   assign bus.o_MAX7219_DataStream = ds;
   assign bus.o_Generation         = gen_q;
   assign bus.o_Stagnant           = stag_q;

endmodule

// File: tb/tb_pattern_life_engine.sv
module tb_pattern_life_engine;

   localparam logic [31:0] SEED = 32'hACE1_2468;
   localparam logic [31:0] TAPS = 32'h8020_0003;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   pattern_life_engine_if #(.DISP_ROWS(1), .DISP_COLUMNS(1), .GEN_WIDTH(16)) bus ();
   pattern_life_engine_if #(.DISP_ROWS(1), .DISP_COLUMNS(1), .GEN_WIDTH(16)) bus_ar ();

   assign bus_ar.i_AliensArrived = bus.i_AliensArrived;
   assign bus_ar.i_Wrap          = bus.i_Wrap;
   assign bus_ar.i_Pause         = bus.i_Pause;
   assign bus_ar.i_Step          = bus.i_Step;

   pattern_life_engine #(
      .DISP_ROWS(1), .DISP_COLUMNS(1), .CLK_FREQ_HZ(8), .GEN_RATE_HZ(1),
      .LFSR_SEED(SEED), .AUTO_RESEED(0), .GEN_WIDTH(16)
   ) dut (
      .i_Clk(clk), .i_Rst(rst), .bus(bus)
   );

   pattern_life_engine #(
      .DISP_ROWS(1), .DISP_COLUMNS(1), .CLK_FREQ_HZ(8), .GEN_RATE_HZ(1),
      .LFSR_SEED(SEED), .AUTO_RESEED(1), .GEN_WIDTH(16)
   ) dut_ar (
      .i_Clk(clk), .i_Rst(rst), .bus(bus_ar)
   );

   int n_run  = 0;
   int n_fail = 0;

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Grid model: bit r*8+c is cell (r,c).
   function automatic logic [63:0] glider();
      logic [63:0] g;
      g = '0;
      g[1] = 1'b1; g[10] = 1'b1; g[16] = 1'b1; g[17] = 1'b1; g[18] = 1'b1;
      return g;
   endfunction

   function automatic logic [63:0] life(input logic [63:0] g, input bit wrap);
      logic [63:0] n;
      n = '0;
      for (int r = 0; r < 8; r++) begin
         for (int c = 0; c < 8; c++) begin
            int cnt;
            cnt = 0;
            for (int dr = -1; dr <= 1; dr++) begin
               for (int dc = -1; dc <= 1; dc++) begin
                  int rr, cc;
                  rr = r + dr;
                  cc = c + dc;
                  if (dr == 0 && dc == 0) continue;
                  if (wrap) begin
                     rr = (rr + 8) % 8;
                     cc = (cc + 8) % 8;
                  end else if (rr < 0 || rr > 7 || cc < 0 || cc > 7) begin
                     continue;
                  end
                  cnt += int'(g[rr*8 + cc]);
               end
            end
            n[r*8 + c] = (cnt == 3) || (g[r*8 + c] && cnt == 2);
         end
      end
      return n;
   endfunction

   function automatic logic [127:0] ds_of(input logic [63:0] g);
      logic [0:7][15:0] w;
      for (int d = 0; d < 8; d++) begin
         w[d][15:8] = 8'(d + 1);
         for (int c = 0; c < 8; c++) w[d][7-c] = g[d*8 + c];
      end
      return w;
   endfunction

   function automatic logic [63:0] lfsr_grid(input logic [31:0] s0);
      logic [31:0] s;
      logic [63:0] g;
      s = s0;
      for (int i = 0; i < 64; i++) begin
         g[i] = s[0];
         s = {1'b0, s[31:1]} ^ (s[0] ? TAPS : 32'h0);
      end
      return g;
   endfunction

   typedef struct packed {
      logic [15:0] gen;
      logic [63:0] grid;
      logic        stag;
   } exp_t;

   exp_t        sb[$];
   logic [63:0] m_cur, m_prev;
   logic [15:0] m_gen;

   task automatic model_reset(input logic [63:0] g);
      m_cur  = g;
      m_prev = '0;
      m_gen  = '0;
   endtask

   task automatic push_gen(input bit wrap);
      logic [63:0] n;
      exp_t        e;
      n      = life(m_cur, wrap);
      e.gen  = m_gen + 16'd1;
      e.grid = n;
      e.stag = (n == m_cur) || (n == m_prev);
      sb.push_back(e);
      m_prev = m_cur;
      m_cur  = n;
      m_gen  = m_gen + 16'd1;
   endtask

   task automatic check_pop(input string tag);
      exp_t e;
      if (sb.size() != 0) begin
         e = sb.pop_front();
         check_eq({tag, "_gen"},  128'(bus.o_Generation), 128'(e.gen));
         check_eq({tag, "_grid"}, 128'(bus.o_MAX7219_DataStream), ds_of(e.grid));
         check_eq({tag, "_stag"}, 128'(bus.o_Stagnant), 128'(e.stag));
      end
   endtask

   task automatic wait_commit(input string tag, input int budget);
      logic [15:0] g0;
      int          i;
      g0 = bus.o_Generation;
      i  = 0;
      while (bus.o_Generation == g0 && i < budget) begin
         @(negedge clk);
         i++;
      end
      check_eq({tag, "_commit_seen"}, 128'(bus.o_Generation != g0), 128'(1));
      check_pop(tag);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [127:0] snap;
      logic [127:0] c_reset, c_gen4, c_block;
      c_reset = {16'h0140, 16'h0220, 16'h03E0, 16'h0400, 16'h0500, 16'h0600, 16'h0700, 16'h0800};
      c_gen4  = {16'h0100, 16'h0220, 16'h0310, 16'h0470, 16'h0500, 16'h0600, 16'h0700, 16'h0800};
      c_block = {16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0500, 16'h0600, 16'h0703, 16'h0803};

      bus.i_AliensArrived = 1'b0;
      bus.i_Wrap          = 1'b1;
      bus.i_Pause         = 1'b1;
      bus.i_Step          = 1'b0;
      rst                 = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      model_reset(glider());

      // Reset state.
      check_eq("reset_grid",    128'(bus.o_MAX7219_DataStream), c_reset);
      check_eq("reset_gen",     128'(bus.o_Generation), 128'(0));
      check_eq("reset_stag",    128'(bus.o_Stagnant), 128'(0));
      check_eq("reset_grid_ar", 128'(bus_ar.o_MAX7219_DataStream), ds_of(glider()));

      // Paused: ticks are ignored.
      repeat (40) @(negedge clk);
      check_eq("pause_grid", 128'(bus.o_MAX7219_DataStream), c_reset);
      check_eq("pause_gen",  128'(bus.o_Generation), 128'(0));

      // Single step: new grid visible exactly 9 edges after the step edge.
      push_gen(1'b1);
      bus.i_Step = 1'b1;
      @(negedge clk);
      bus.i_Step = 1'b0;
      repeat (8) @(negedge clk);
      check_eq("step_not_yet", 128'(bus.o_MAX7219_DataStream), c_reset);
      @(negedge clk);
      check_pop("step");

      // Free-running toroidal glider up to generation 4.
      push_gen(1'b1);
      push_gen(1'b1);
      push_gen(1'b1);
      bus.i_Pause = 1'b0;
      for (int i = 0; i < 3; i++) wait_commit("wrap_run", 40);
      bus.i_Pause = 1'b1;
      check_eq("gen4_grid", 128'(bus.o_MAX7219_DataStream), c_gen4);

      // Reseed request during COMPUTE: generation 5 commits, then SEED.
      push_gen(1'b1);
      bus.i_Step = 1'b1;
      @(negedge clk);
      bus.i_Step          = 1'b0;
      bus.i_AliensArrived = 1'b1;
      @(negedge clk);
      bus.i_AliensArrived = 1'b0;
      wait_commit("alien_commit", 40);
      for (int i = 0; i < 100 && bus.o_Generation != 16'd0; i++) @(negedge clk);
      check_eq("seed_gen",  128'(bus.o_Generation), 128'(0));
      check_eq("seed_grid", 128'(bus.o_MAX7219_DataStream), ds_of(lfsr_grid(SEED)));
      check_eq("seed_stag", 128'(bus.o_Stagnant), 128'(0));
      snap = bus.o_MAX7219_DataStream;
      repeat (20) @(negedge clk);
      check_eq("no_reseed_grid", 128'(bus.o_MAX7219_DataStream), ds_of(lfsr_grid(SEED)));
      check_eq("no_reseed_gen",  128'(bus.o_Generation), 128'(0));

      // Reset in the middle of SEED restores the glider and stops seeding.
      bus.i_AliensArrived = 1'b1;
      @(negedge clk);
      bus.i_AliensArrived = 1'b0;
      repeat (20) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_eq("rst_seed_grid",    128'(bus.o_MAX7219_DataStream), c_reset);
      check_eq("rst_seed_gen",     128'(bus.o_Generation), 128'(0));
      check_eq("rst_seed_grid_ar", 128'(bus_ar.o_MAX7219_DataStream), c_reset);
      rst = 1'b0;
      model_reset(glider());
      repeat (80) @(negedge clk);
      check_eq("rst_seed_hold", 128'(bus.o_MAX7219_DataStream), c_reset);
      check_eq("rst_seed_hold_ar", 128'(bus_ar.o_MAX7219_DataStream), c_reset);

      // Dead edges: glider runs into the corner and settles.
      do begin
         push_gen(1'b0);
      end while (!sb[$].stag && m_gen < 16'd64);
      bus.i_Wrap  = 1'b0;
      bus.i_Pause = 1'b0;
      while (sb.size() > 0) wait_commit("edge_run", 40);
      check_eq("block_grid", 128'(bus.o_MAX7219_DataStream), c_block);
      check_eq("block_stag", 128'(bus.o_Stagnant), 128'(1));
      push_gen(1'b0);
      wait_commit("block_hold", 40);

      // The auto-reseeding twin went straight into SEED on stagnation.
      for (int i = 0; i < 100 && bus_ar.o_Generation != 16'd0; i++) @(negedge clk);
      check_eq("auto_seed_gen",  128'(bus_ar.o_Generation), 128'(0));
      check_eq("auto_seed_grid", 128'(bus_ar.o_MAX7219_DataStream), ds_of(lfsr_grid(SEED)));
      check_eq("auto_seed_stag", 128'(bus_ar.o_Stagnant), 128'(0));

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
